// File: rtl/jpegls_ctx_predict_if.sv
// Sample/result stream bundle for jpegls_ctx_predict.
//   in_valid/in_ready : input handshake, Ra/Rb/Rc/Rd/Ix neighbours + current sample
//   out_valid/out_ready: output handshake, out_q/out_sign/out_px/out_err/out_a/out_n
// master = producer of samples / consumer of results, slave = the predictor.
interface jpegls_ctx_predict_if #(
  parameter int BPP = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [BPP-1:0] Ra, Rb, Rc, Rd, Ix;
  logic           out_valid;
  logic           out_ready;
  logic [8:0]     out_q;
  logic           out_sign;
  logic [BPP-1:0] out_px;
  logic [BPP-1:0] out_err;
  logic [BPP+6:0] out_a;
  logic [6:0]     out_n;

  modport master (
    output in_valid, Ra, Rb, Rc, Rd, Ix, out_ready,
    input  in_ready, out_valid, out_q, out_sign, out_px, out_err, out_a, out_n
  );
  modport slave (
    input  in_valid, Ra, Rb, Rc, Rd, Ix, out_ready,
    output in_ready, out_valid, out_q, out_sign, out_px, out_err, out_a, out_n
  );
endinterface

// File: rtl/jpegls_ctx_predict.sv
// JPEG-LS context modelling + MED prediction, two-stage pipeline.
//   clk, rst    : clock, asynchronous active-high reset
//   bus (slave) : sample in / result out streams (see jpegls_ctx_predict_if)
//   init_busy   : high while the 405-entry context tables are being initialised
// S1 registers the quantised context index, sign and MED prediction.
// S2 reads the context tables combinationally, produces the corrected
// prediction and error, and on the same edge that loads the output register
// writes the updated context back. A same-context sample following directly
// therefore reads the freshly written entry with no forwarding needed.
module jpegls_ctx_predict #(
  parameter int BPP     = 8,
  parameter int T1      = 3,
  parameter int T2      = 7,
  parameter int T3      = 21,
  parameter int NEAR    = 0,
  parameter int RESET_N = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  jpegls_ctx_predict_if.slave    bus,
  output logic                   init_busy
);
  localparam int MAXVAL = (1 << BPP) - 1;
  localparam int AW     = BPP + 7;
  localparam int BW     = BPP + 8;
  localparam int NCTX   = 405;
  localparam int A_RAW  = ((1 << BPP) + 32) >> 6;
  localparam int A_INIT = (A_RAW > 2) ? A_RAW : 2;

  typedef enum logic {INIT, RUN} state_t;
  state_t     state, state_nx;
  logic [8:0] init_idx, init_idx_nx;

  logic advance, accept, upd;

  // context tables
  logic [AW-1:0]        tab_a [NCTX];
  logic signed [BW-1:0] tab_b [NCTX];
  logic signed [7:0]    tab_c [NCTX];
  logic [6:0]           tab_n [NCTX];

  // ---------------- init sweep FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nx;
      init_idx <= init_idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_idx_nx = init_idx;
    if (state == INIT) begin
      if (init_idx == 9'(NCTX - 1)) begin
        state_nx    = RUN;
        init_idx_nx = '0;
      end else begin
        init_idx_nx = init_idx + 9'd1;
      end
    end
  end

  assign init_busy    = (state == INIT);
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance && (state == RUN);
  assign accept       = bus.in_valid && bus.in_ready;

  // ---------------- stage 1 combinational ----------------
  function automatic logic signed [3:0] quant(input logic signed [BPP:0] d);
    int v;
    v = int'(d);
    if      (v <= -T3)   quant = -4'sd4;
    else if (v <= -T2)   quant = -4'sd3;
    else if (v <= -T1)   quant = -4'sd2;
    else if (v < -NEAR)  quant = -4'sd1;
    else if (v <= NEAR)  quant =  4'sd0;
    else if (v < T1)     quant =  4'sd1;
    else if (v < T2)     quant =  4'sd2;
    else if (v < T3)     quant =  4'sd3;
    else                 quant =  4'sd4;
  endfunction

  logic signed [BPP:0] d1, d2, d3;
  logic signed [3:0]   q1, q2, q3, m1, m2, m3;
  logic                neg;
  logic [8:0]          qidx;
  logic [BPP-1:0]      mx, mn, px_med;

  always_comb begin
    d1 = $signed({1'b0, bus.Rd}) - $signed({1'b0, bus.Rb});
    d2 = $signed({1'b0, bus.Rb}) - $signed({1'b0, bus.Rc});
    d3 = $signed({1'b0, bus.Rc}) - $signed({1'b0, bus.Ra});
    q1 = quant(d1);
    q2 = quant(d2);
    q3 = quant(d3);
    // first nonzero component decides the sign
    neg = (q1 < 0) || ((q1 == 0) && ((q2 < 0) || ((q2 == 0) && (q3 < 0))));
    m1  = neg ? -q1 : q1;
    m2  = neg ? -q2 : q2;
    m3  = neg ? -q3 : q3;
    qidx = 9'((int'(m1) * 9 + int'(m2) + 4) * 9 + int'(m3) + 4);
    // MED predictor
    mx = (bus.Ra > bus.Rb) ? bus.Ra : bus.Rb;
    mn = (bus.Ra > bus.Rb) ? bus.Rb : bus.Ra;
    if (bus.Rc >= mx)      px_med = mn;
    else if (bus.Rc <= mn) px_med = mx;
    else                   px_med = bus.Ra + bus.Rb - bus.Rc;
  end

  // ---------------- stage 1 registers ----------------
  logic           s1_vld, s1_sign;
  logic [8:0]     s1_q;
  logic [BPP-1:0] s1_px, s1_ix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_q    <= '0;
      s1_px   <= '0;
      s1_ix   <= '0;
    end else if (advance) begin
      s1_vld <= accept;
      if (accept) begin
        s1_sign <= neg;
        s1_q    <= qidx;
        s1_px   <= px_med;
        s1_ix   <= bus.Ix;
      end
    end
  end

  // ---------------- stage 2 combinational ----------------
  logic [AW-1:0]        a_cur;
  logic signed [BW-1:0] b_cur;
  logic signed [7:0]    c_cur;
  logic [6:0]           n_cur;
  logic [BPP-1:0]       err_r;
  int pxc, e_full, e, a_nx, b_nx, c_nx, n_nx;

  always_comb begin
    a_cur = tab_a[s1_q];
    b_cur = tab_b[s1_q];
    c_cur = tab_c[s1_q];
    n_cur = tab_n[s1_q];

    pxc = s1_sign ? int'(s1_px) - int'(c_cur) : int'(s1_px) + int'(c_cur);
    if (pxc < 0)           pxc = 0;
    else if (pxc > MAXVAL) pxc = MAXVAL;

    e_full = int'(s1_ix) - pxc;
    if (s1_sign) e_full = -e_full;
    // low BPP bits read as two's complement = modulo reduction
    err_r = BPP'(e_full);
    e     = int'($signed(err_r));

    a_nx = int'(a_cur) + ((e < 0) ? -e : e);
    b_nx = int'(b_cur) + e;
    n_nx = int'(n_cur);
    c_nx = int'(c_cur);
    if (n_nx == RESET_N) begin
      a_nx = a_nx >> 1;
      b_nx = b_nx >>> 1;
      n_nx = n_nx >> 1;
    end
    n_nx = n_nx + 1;

    // bias cancellation uses the already-incremented N
    if (b_nx <= -n_nx) begin
      b_nx = b_nx + n_nx;
      if (c_nx > -128) c_nx = c_nx - 1;
      if (b_nx <= -n_nx) b_nx = -n_nx + 1;
    end else if (b_nx > 0) begin
      b_nx = b_nx - n_nx;
      if (c_nx < 127) c_nx = c_nx + 1;
      if (b_nx > 0) b_nx = 0;
    end
  end

  // table write happens only when S2 retires into the output register,
  // so a stalled sample is applied exactly once
  assign upd = advance && s1_vld && (state == RUN);

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      tab_a[init_idx] <= AW'(A_INIT);
      tab_b[init_idx] <= '0;
      tab_c[init_idx] <= '0;
      tab_n[init_idx] <= 7'd1;
    end else if (upd) begin
      tab_a[s1_q] <= AW'(a_nx);
      tab_b[s1_q] <= BW'(b_nx);
      tab_c[s1_q] <= 8'(c_nx);
      tab_n[s1_q] <= 7'(n_nx);
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_q     <= '0;
      bus.out_sign  <= 1'b0;
      bus.out_px    <= '0;
      bus.out_err   <= '0;
      bus.out_a     <= '0;
      bus.out_n     <= '0;
    end else if (advance) begin
      bus.out_valid <= upd;
      if (upd) begin
        bus.out_q    <= s1_q;
        bus.out_sign <= s1_sign;
        bus.out_px   <= BPP'(pxc);
        bus.out_err  <= err_r;
        bus.out_a    <= a_cur;
        bus.out_n    <= n_cur;
      end
    end
  end
endmodule

// File: tb/tb_jpegls_ctx_predict.sv
module tb_jpegls_ctx_predict;
  logic clk, rst, init_busy;
  int checks = 0;
  int errors = 0;

  jpegls_ctx_predict_if #(.BPP(8)) bus ();

  jpegls_ctx_predict #(.BPP(8), .T1(3), .T2(7), .T3(21), .NEAR(0), .RESET_N(64)) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int q; int sign; int px; int err; int a; int n; } exp_t;
  exp_t sb[$];

  // reference context tables
  int mA[405], mB[405], mC[405], mN[405];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void minit();
    for (int i = 0; i < 405; i++) begin
      mA[i] = 4; mB[i] = 0; mC[i] = 0; mN[i] = 1;
    end
  endfunction

  function automatic int qz(int d);
    if (d <= -21) return -4;
    if (d <= -7)  return -3;
    if (d <= -3)  return -2;
    if (d < 0)    return -1;
    if (d == 0)   return 0;
    if (d < 3)    return 1;
    if (d < 7)    return 2;
    if (d < 21)   return 3;
    return 4;
  endfunction

  function automatic exp_t predict(int ra, int rb, int rc, int rd, int ix);
    exp_t r;
    int g1, g2, g3, s, q, px, p2, err, mxv, mnv;
    g1 = qz(rd - rb); g2 = qz(rb - rc); g3 = qz(rc - ra);
    s = 0;
    if (g1 != 0) s = (g1 < 0);
    else if (g2 != 0) s = (g2 < 0);
    else s = (g3 < 0);
    if (s) begin g1 = -g1; g2 = -g2; g3 = -g3; end
    q = (g1 * 9 + g2 + 4) * 9 + g3 + 4;
    mxv = (ra > rb) ? ra : rb;
    mnv = (ra > rb) ? rb : ra;
    if (rc >= mxv) px = mnv;
    else if (rc <= mnv) px = mxv;
    else px = ra + rb - rc;
    p2 = s ? px - mC[q] : px + mC[q];
    if (p2 < 0) p2 = 0;
    if (p2 > 255) p2 = 255;
    err = ix - p2;
    if (s) err = -err;
    while (err < -128) err += 256;
    while (err > 127) err -= 256;
    r.q = q; r.sign = s; r.px = p2; r.err = err & 255; r.a = mA[q]; r.n = mN[q];
    mB[q] += err;
    mA[q] += (err < 0) ? -err : err;
    if (mN[q] == 64) begin
      mA[q] = mA[q] / 2; mB[q] = mB[q] >>> 1; mN[q] = mN[q] / 2;
    end
    mN[q] += 1;
    if (mB[q] <= -mN[q]) begin
      mB[q] += mN[q];
      if (mC[q] > -128) mC[q] -= 1;
      if (mB[q] <= -mN[q]) mB[q] = -mN[q] + 1;
    end else if (mB[q] > 0) begin
      mB[q] -= mN[q];
      if (mC[q] < 127) mC[q] += 1;
      if (mB[q] > 0) mB[q] = 0;
    end
    return r;
  endfunction

  task automatic drive(input int ra, input int rb, input int rc, input int rd, input int ix);
    int n;
    bus.Ra = 8'(ra); bus.Rb = 8'(rb); bus.Rc = 8'(rc); bus.Rd = 8'(rd); bus.Ix = 8'(ix);
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input int ra, input int rb, input int rc, input int rd, input int ix);
    sb.push_back(predict(ra, rb, rc, rd, ix));
    drive(ra, rb, rc, rd, ix);
  endtask

  // called with rst high; releases it and times the init sweep
  task automatic release_and_init();
    int cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    minit();
    sb.delete();
    cnt = 0;
    @(negedge clk);
    check("in_ready_during_init", 32'(bus.in_ready), 32'd0);
    while (init_busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("init_cycles", 32'(cnt), 32'd405);
    check("in_ready_after_init", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    logic [8:0] sq;
    logic [7:0] spx, serr;
    int v, n;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.Ra = '0; bus.Rb = '0; bus.Rc = '0; bus.Rd = '0; bus.Ix = '0;

    // output scoreboard monitor
    fork
      forever begin
        exp_t m;
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
          else begin
            m = sb.pop_front();
            check("out_q",    32'(bus.out_q),    32'(m.q));
            check("out_sign", 32'(bus.out_sign), 32'(m.sign));
            check("out_px",   32'(bus.out_px),   32'(m.px));
            check("out_err",  32'(bus.out_err),  32'(m.err));
            check("out_a",    32'(bus.out_a),    32'(m.a));
            check("out_n",    32'(bus.out_n),    32'(m.n));
          end
        end
      end
      begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_q",     32'(bus.out_q),     32'd0);
    check("rst_out_px",    32'(bus.out_px),    32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    check("rst_out_a",     32'(bus.out_a),     32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_init_busy", 32'(init_busy),     32'd1);
    release_and_init();

    // all-255 neighbours, Ix=0: prediction 255, error wraps to +1
    e = predict(255, 255, 255, 255, 0);
    e.q = 40; e.sign = 0; e.px = 255; e.err = 1; e.a = 4; e.n = 1;
    sb.push_back(e);
    drive(255, 255, 255, 255, 0);

    // random burst, then reset in the middle of it
    for (int i = 0; i < 6; i++)
      send($urandom_range(255), $urandom_range(255), $urandom_range(255),
           $urandom_range(255), $urandom_range(255));
    check("stream_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_init_busy", 32'(init_busy), 32'd1);
    release_and_init();

    // flat neighbours, Ix=103 twice
    e = predict(100, 100, 100, 100, 103);
    e.q = 40; e.sign = 0; e.px = 100; e.err = 3; e.a = 4; e.n = 1;
    sb.push_back(e);
    drive(100, 100, 100, 100, 103);
    e = predict(100, 100, 100, 100, 103);
    e.q = 40; e.px = 101; e.err = 2; e.n = 2;
    sb.push_back(e);
    drive(100, 100, 100, 100, 103);

    // sign-merged context
    e = predict(100, 100, 100, 50, 90);
    e.q = 364; e.sign = 1; e.px = 100; e.err = 10; e.a = 4; e.n = 1;
    sb.push_back(e);
    drive(100, 100, 100, 50, 90);

    // back-pressure: three same-context samples, output stalled 5 clocks
    repeat (3) @(posedge clk);
    #1;
    send(120, 120, 120, 120, 125);
    bus.out_ready = 1'b0;
    send(120, 120, 120, 120, 118);
    bus.Ix = 8'd123; bus.in_valid = 1'b1;
    sq = '0; spx = '0; serr = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      if (k == 0) begin
        sq = bus.out_q; spx = bus.out_px; serr = bus.out_err;
      end else begin
        check("stall_q",   32'(bus.out_q),   32'(sq));
        check("stall_px",  32'(bus.out_px),  32'(spx));
        check("stall_err", 32'(bus.out_err), 32'(serr));
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(120, 120, 120, 120, 123);

    // long same-context run: exercises N halving and bias correction
    for (int i = 0; i < 90; i++) begin
      v = $urandom_range(200, 40);
      send(v, v, v, v, v + $urandom_range(8) - 3);
    end

    // fully random samples
    for (int i = 0; i < 120; i++)
      send($urandom_range(255), $urandom_range(255), $urandom_range(255),
           $urandom_range(255), $urandom_range(255));

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
